// File: rtl/nn_pkg.sv
// Shared network definitions: default score geometry, the argmax state
// encoding and the most-negative score constant.
package nn_pkg;

  localparam int DEF_SCORE_W     = 32;
  localparam int DEF_NUM_CLASSES = 10;

  localparam logic [DEF_SCORE_W-1:0] SCORE_MIN = {1'b1, {(DEF_SCORE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/argmax_update.sv
// One step of the running argmax: folds score s at index k into the
// current best/second/idx. Strict compares keep ties on the lowest index.
module argmax_update #(
  parameter int SCORE_W = 32,
  parameter int IDX_W   = 4
) (
  input  logic [SCORE_W-1:0] s,
  input  logic [IDX_W-1:0]   k,
  input  logic [SCORE_W-1:0] best,
  input  logic [SCORE_W-1:0] second,
  input  logic [IDX_W-1:0]   idx,
  output logic [SCORE_W-1:0] best_nxt,
  output logic [SCORE_W-1:0] second_nxt,
  output logic [IDX_W-1:0]   idx_nxt
);

  always_comb begin
    // NOTE: every output gets a default before the branches so no latch is inferred.
    best_nxt   = best;
    second_nxt = second;
    idx_nxt    = idx;
    if ($signed(s) > $signed(best)) begin
      second_nxt = best;
      best_nxt   = s;
      idx_nxt    = k;
    end else if ($signed(s) > $signed(second)) begin
      // A tie with best lands here: second takes the value, idx stays put.
      second_nxt = s;
    end
  end

endmodule

// File: rtl/output_argmax.sv
// Captures the network's class scores on done, scans them one per cycle
// and presents index, top-two scores and margin over valid/ready.
module output_argmax
  import nn_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int IDX_W       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         scores_valid,
  input  logic [NUM_CLASSES*SCORE_W-1:0] scores_in,
  output logic                         busy,
  output logic                         class_valid,
  input  logic                         class_ready,
  output logic [IDX_W-1:0]             class_idx,
  output logic [SCORE_W-1:0]           max_score,
  output logic [SCORE_W-1:0]           second_score,
  output logic [SCORE_W-1:0]           margin,
  output logic                         overrun
);

  localparam logic [SCORE_W-1:0] L_SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]   L_LAST_K    = IDX_W'(NUM_CLASSES - 1);

  state_t             r_state;
  logic [SCORE_W-1:0] r_scores [NUM_CLASSES];
  logic [IDX_W-1:0]   r_k;
  logic [SCORE_W-1:0] r_best;
  logic [SCORE_W-1:0] r_second;
  logic [IDX_W-1:0]   r_idx;

  logic [SCORE_W-1:0] w_s;
  logic [SCORE_W-1:0] w_best_nxt;
  logic [SCORE_W-1:0] w_second_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_capture;
  logic               w_drop;

  // A pulse is taken in IDLE, or in HOLD when the result leaves the same cycle.
  assign w_capture = scores_valid &&
                     ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && class_ready));
  assign w_drop    = scores_valid && !w_capture;
  assign w_s       = r_scores[r_k];

  argmax_update #(
    .SCORE_W (SCORE_W),
    .IDX_W   (IDX_W)
  ) u_update (
    .s          (w_s),
    .k          (r_k),
    .best       (r_best),
    .second     (r_second),
    .idx        (r_idx),
    .best_nxt   (w_best_nxt),
    .second_nxt (w_second_nxt),
    .idx_nxt    (w_idx_nxt)
  );

  // NOTE: the score array is plain storage that is always written before it is read, so it has no reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        r_scores[i] <= scores_in[i*SCORE_W +: SCORE_W];
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_k          <= '0;
      r_best       <= '0;
      r_second     <= '0;
      r_idx        <= '0;
      busy         <= 1'b0;
      class_valid  <= 1'b0;
      class_idx    <= '0;
      max_score    <= '0;
      second_score <= '0;
      margin       <= '0;
      overrun      <= 1'b0;
    end else begin
      if (w_drop) overrun <= 1'b1;

      case (r_state)
        ST_SCAN: begin
          r_best   <= w_best_nxt;
          r_second <= w_second_nxt;
          r_idx    <= w_idx_nxt;
          if (r_k == L_LAST_K) begin
            r_state      <= ST_HOLD;
            busy         <= 1'b0;
            class_valid  <= 1'b1;
            class_idx    <= w_idx_nxt;
            max_score    <= w_best_nxt;
            second_score <= w_second_nxt;
            // best >= second, so the low SCORE_W bits of the wide difference are exact.
            margin       <= w_best_nxt - w_second_nxt;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        ST_HOLD: begin
          if (class_ready) begin
            class_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        ST_IDLE: ;
        default: r_state <= ST_IDLE;
      endcase

      // Overrides the HOLD exit above when a new frame arrives on the handshake.
      if (w_capture) begin
        r_state  <= ST_SCAN;
        busy     <= 1'b1;
        r_k      <= IDX_W'(1);
        r_best   <= scores_in[SCORE_W-1:0];
        r_second <= L_SCORE_MIN;
        r_idx    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_output_argmax.sv
// Scenario bench for output_argmax: a reference model fills a scoreboard
// when frames are driven and each scenario pops it when a result appears.
module tb_output_argmax;
  import nn_pkg::*;

  localparam int N  = 10;
  localparam int W  = 32;
  localparam int IW = 4;

  typedef logic [W-1:0] score_arr_t [N];
  typedef struct packed {
    logic [IW-1:0] idx;
    logic [W-1:0]  max;
    logic [W-1:0]  second;
    logic [W-1:0]  margin;
  } result_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           scores_valid = 1'b0;
  logic [N*W-1:0] scores_in = '0;
  logic           busy;
  logic           class_valid;
  logic           class_ready = 1'b0;
  logic [IW-1:0]  class_idx;
  logic [W-1:0]   max_score;
  logic [W-1:0]   second_score;
  logic [W-1:0]   margin;
  logic           overrun;

  result_t sb_q[$];
  int      checks = 0;
  int      errors = 0;

  output_argmax #(.NUM_CLASSES(N), .SCORE_W(W), .IDX_W(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scores_valid (scores_valid),
    .scores_in    (scores_in),
    .busy         (busy),
    .class_valid  (class_valid),
    .class_ready  (class_ready),
    .class_idx    (class_idx),
    .max_score    (max_score),
    .second_score (second_score),
    .margin       (margin),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Reference: first maximum wins; second is the best of the remaining entries.
  function automatic result_t model(input score_arr_t s);
    result_t r;
    int      bi;
    logic [W-1:0] sec;
    longint  diff;
    bi = 0;
    for (int i = 1; i < N; i++) if ($signed(s[i]) > $signed(s[bi])) bi = i;
    sec = SCORE_MIN;
    for (int i = 0; i < N; i++) if (i != bi && $signed(s[i]) > $signed(sec)) sec = s[i];
    diff     = longint'($signed(s[bi])) - longint'($signed(sec));
    r.idx    = IW'(bi);
    r.max    = s[bi];
    r.second = sec;
    r.margin = diff[W-1:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input score_arr_t s, input bit accepted);
    for (int i = 0; i < N; i++) scores_in[i*W +: W] = s[i];
    scores_valid = 1'b1;
    if (accepted) sb_q.push_back(model(s));
    tick();
    scores_valid = 1'b0;
    scores_in    = {N{32'hDEAD_BEEF}};
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!class_valid && cycles < 60) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if ({busy, class_valid, class_idx, max_score, second_score, margin, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b valid=%b idx=%0d max=%h sec=%h margin=%h ovr=%b, expected all zero",
               busy, class_valid, class_idx, max_score, second_score, margin, overrun);
    end
  endtask

  task automatic run_and_check(input string name, input score_arr_t s);
    result_t exp;
    int      cyc;
    class_ready = 1'b1;
    send(s, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: got %b, expected 1", name, busy);
    end
    wait_valid(cyc);
    checks++;
    if (cyc !== N - 1) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, expected %0d", name, cyc, N - 1);
    end
    exp = sb_q.pop_front();
    checks++;
    if ({class_idx, max_score, second_score, margin} !== exp) begin
      errors++;
      $display("FAIL %s_result: got idx=%0d max=%h sec=%h margin=%h, expected idx=%0d max=%h sec=%h margin=%h",
               name, class_idx, max_score, second_score, margin, exp.idx, exp.max, exp.second, exp.margin);
    end
    tick();
    checks++;
    if (class_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: class_valid got %b after handshake, expected 0", name, class_valid);
    end
  endtask

  task automatic test_distinct();
    score_arr_t s = '{5, -3, 100, 7, 0, 2, 99, -50, 1, 3};
    run_and_check("distinct", s);
  endtask

  task automatic test_tie();
    score_arr_t s;
    for (int i = 0; i < N; i++) s[i] = -10;
    s[4] = -2;
    s[7] = -2;
    run_and_check("tie", s);
    checks++;
    if (class_idx !== 4'd4 || margin !== '0) begin
      errors++;
      $display("FAIL tie_lowest_idx: got idx=%0d margin=%h, expected idx=4 margin=0", class_idx, margin);
    end
  endtask

  task automatic test_extreme();
    score_arr_t s;
    for (int i = 0; i < N; i++) s[i] = SCORE_MIN;
    s[9] = 32'h7FFF_FFFF;
    run_and_check("extreme", s);
    checks++;
    if (class_idx !== 4'd9 || second_score !== SCORE_MIN || margin !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL extreme_range: got idx=%0d sec=%h margin=%h, expected idx=9 sec=80000000 margin=ffffffff",
               class_idx, second_score, margin);
    end
  endtask

  task automatic test_backpressure();
    score_arr_t s = '{-7, 40, 3, 40, 12, -1, 0, 39, 8, 2};
    result_t    exp;
    result_t    snap;
    int         cyc;
    int         bad;
    class_ready = 1'b0;
    send(s, 1'b1);
    wait_valid(cyc);
    checks++;
    if (cyc !== N - 1) begin
      errors++;
      $display("FAIL bp_latency: got %0d cycles, expected %0d", cyc, N - 1);
    end
    snap = {class_idx, max_score, second_score, margin};
    bad  = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        scores_valid = 1'b1;
        for (int j = 0; j < N; j++) scores_in[j*W +: W] = $urandom;
      end
      tick();
      scores_valid = 1'b0;
      if (!class_valid || {class_idx, max_score, second_score, margin} !== snap) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stable: %0d cycles changed or lost valid, expected 0", bad);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_overrun: got %b, expected 1", overrun);
    end
    exp = sb_q.pop_front();
    checks++;
    if ({class_idx, max_score, second_score, margin} !== exp) begin
      errors++;
      $display("FAIL bp_result: got idx=%0d max=%h sec=%h margin=%h, expected idx=%0d max=%h sec=%h margin=%h",
               class_idx, max_score, second_score, margin, exp.idx, exp.max, exp.second, exp.margin);
    end
    class_ready = 1'b1;
    tick();
    checks++;
    if (class_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got valid=%b busy=%b, expected 0 0", class_valid, busy);
    end
  endtask

  task automatic test_reset_mid_scan();
    score_arr_t s = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    score_arr_t c = '{-4, 8, 8, -9, 0, 6, 1, 2, 7, 3};
    int         seen;
    class_ready = 1'b1;
    send(s, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({busy, class_valid, class_idx, max_score, second_score, margin, overrun} !== '0) begin
      errors++;
      $display("FAIL midscan_reset: got busy=%b valid=%b idx=%0d max=%h sec=%h margin=%h ovr=%b, expected all zero",
               busy, class_valid, class_idx, max_score, second_score, margin, overrun);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (class_valid || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midscan_no_result: activity seen on %0d cycles, expected 0", seen);
    end
    run_and_check("post_reset", c);
  endtask

  task automatic test_back_to_back();
    score_arr_t a = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    score_arr_t b = '{0, 0, 0, 9, 0, 0, 0, 0, 0, 0};
    result_t    exp;
    int         cyc;
    class_ready = 1'b0;
    send(a, 1'b1);
    wait_valid(cyc);
    exp = sb_q.pop_front();
    checks++;
    if (!class_valid || {class_idx, max_score, second_score, margin} !== exp) begin
      errors++;
      $display("FAIL b2b_first: got valid=%b idx=%0d max=%h sec=%h margin=%h, expected valid=1 idx=%0d max=%h sec=%h margin=%h",
               class_valid, class_idx, max_score, second_score, margin, exp.idx, exp.max, exp.second, exp.margin);
    end
    class_ready = 1'b1;
    send(b, 1'b1);
    checks++;
    if (busy !== 1'b1 || class_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: got busy=%b valid=%b, expected busy=1 valid=0", busy, class_valid);
    end
    wait_valid(cyc);
    checks++;
    if (cyc !== N - 1) begin
      errors++;
      $display("FAIL b2b_latency: got %0d cycles, expected %0d", cyc, N - 1);
    end
    exp = sb_q.pop_front();
    checks++;
    if ({class_idx, max_score, second_score, margin} !== exp || class_idx !== 4'd3) begin
      errors++;
      $display("FAIL b2b_second: got idx=%0d max=%h sec=%h margin=%h, expected idx=%0d max=%h sec=%h margin=%h",
               class_idx, max_score, second_score, margin, exp.idx, exp.max, exp.second, exp.margin);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overrun: got %b, expected 0", overrun);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_distinct();
    test_tie();
    test_extreme();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
